// File: rtl/adder_8bit.sv
// Registered unsigned ripple-carry adder for the shift-add multiplier datapath.
// One full-adder cell per bit; sum/carry are registered for a fixed 1-cycle latency.

module adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;
  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             out_valid_d, out_valid_q;

  assign c[0] = 1'b0;

  // c[i+1] of cell i feeds c_i of cell i+1, forming the ripple chain
  adder_fa u_fa [WIDTH-1:0] (
    .a_i (a),
    .b_i (m),
    .c_i (c[WIDTH-1:0]),
    .s_o (s),
    .c_o (c[WIDTH:1])
  );

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = s;
      carry_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_adder_8bit.sv
// Scoreboard bench for adder_8bit: expected results are queued when operands are
// driven and popped one edge later when the registered result appears.

module tb_adder_8bit;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] a, m;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_print  = 0;

  adder_8bit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .m         (m),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus; queue the reference result for accepted operands.
  task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] mv);
    logic [WIDTH:0] full;
    res_t e;
    rst = r; in_valid = v; a = av; m = mv;
    full = {1'b0, av} + {1'b0, mv};
    e.sum = full[WIDTH-1:0];
    e.carry = full[WIDTH];
    if (v && !r) exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 8'hFF, 8'h01);
      tick();
      n_checks++;
      if ({sum, carry, out_valid} !== {8'h00, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got sum=%h carry=%b ov=%b, want sum=00 carry=0 ov=0",
                 i, sum, carry, out_valid);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_exhaustive();
    res_t e;
    for (int i = 0; i < 65536; i++) begin
      drive(1'b0, 1'b1, i[15:8], i[7:0]);
      tick();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({sum, carry, out_valid} !== {e.sum, e.carry, 1'b1}) begin
        n_fail++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL exhaustive a=%h m=%h: got sum=%h carry=%b ov=%b, want sum=%h carry=%b ov=1",
                   i[15:8], i[7:0], sum, carry, out_valid, e.sum, e.carry);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    logic [WIDTH-1:0] ta[4] = '{8'hFF, 8'hFF, 8'h80, 8'h00};
    logic [WIDTH-1:0] tm[4] = '{8'h01, 8'hFF, 8'h7F, 8'h00};
    logic [WIDTH-1:0] ws[4] = '{8'h00, 8'hFE, 8'hFF, 8'h00};
    logic             wc[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    res_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, ta[i], tm[i]);
      tick();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({sum, carry, out_valid} !== {ws[i], wc[i], 1'b1} || e !== {ws[i], wc[i]}) begin
        n_fail++;
        $display("FAIL boundary a=%h m=%h: got sum=%h carry=%b ov=%b, want sum=%h carry=%b ov=1",
                 ta[i], tm[i], sum, carry, out_valid, ws[i], wc[i]);
      end
    end
  endtask

  task automatic test_hold();
    res_t e;
    drive(1'b0, 1'b1, 8'h12, 8'h34);
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if ({sum, carry, out_valid} !== {8'h46, 1'b0, 1'b1} || e !== {8'h46, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_load: got sum=%h carry=%b ov=%b, want sum=46 carry=0 ov=1",
               sum, carry, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'($urandom), 8'($urandom) | 8'h80);
      tick();
      n_checks++;
      if ({sum, carry, out_valid} !== {8'h46, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got sum=%h carry=%b ov=%b, want sum=46 carry=0 ov=0",
                 i, sum, carry, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    logic [WIDTH-1:0] av, mv;
    for (int i = 0; i < 32; i++) begin
      av = 8'($urandom);
      mv = 8'($urandom);
      drive(1'b0, 1'b1, av, mv);
      tick();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({sum, carry, out_valid} !== {e.sum, e.carry, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b a=%h m=%h: got sum=%h carry=%b ov=%b, want sum=%h carry=%b",
                 av, mv, sum, carry, out_valid, e.sum, e.carry);
      end
    end
  endtask

  task automatic test_reset_midstream();
    res_t e;
    drive(1'b0, 1'b1, 8'hC0, 8'h55);
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if ({sum, carry, out_valid} !== {8'h15, 1'b1, 1'b1} || e !== {8'h15, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_pre: got sum=%h carry=%b ov=%b, want sum=15 carry=1 ov=1",
               sum, carry, out_valid);
    end
    drive(1'b1, 1'b1, 8'hAA, 8'hAA);
    tick();
    n_checks++;
    if ({sum, carry, out_valid} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got sum=%h carry=%b ov=%b, want sum=00 carry=0 ov=0",
               sum, carry, out_valid);
    end
    drive(1'b0, 1'b1, 8'h21, 8'h0F);
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if ({sum, carry, out_valid} !== {8'h30, 1'b0, 1'b1} || e !== {8'h30, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_post: got sum=%h carry=%b ov=%b, want sum=30 carry=0 ov=1",
               sum, carry, out_valid);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, '0);
    #1;
    test_reset();
    test_exhaustive();
    test_boundaries();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_8bit.md
Name: adder_8bit

Overview:
Registered unsigned binary adder for the shift-add multiplier datapath. It adds the accumulator operand `a` to the multiplicand operand `m` and returns the WIDTH-bit sum and the carry-out. The sum is built as an explicit ripple-carry chain of per-bit full-adder cells. Outputs are registered once, so the accumulator control sees a fixed 1-cycle latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands on a/m are valid this cycle.
- a  input  WIDTH  unsigned operand (accumulator side).
- m  input  WIDTH  unsigned operand (multiplicand side).
- sum  output  WIDTH  registered low WIDTH bits of a+m.
- carry  output  1  registered carry-out (bit WIDTH of a+m).
- out_valid  output  1  sum/carry were updated by the previous cycle's in_valid.

Behaviour:
- Reset is synchronous: on a rising clk edge with rst=1, sum=0, carry=0 and out_valid=0. Operands sampled on that edge are discarded. Reset overrides in_valid.
- Datapath:
  - Bit i computes s_i = a_i ^ m_i ^ c_i and c_(i+1) = (a_i & m_i) | (c_i & (a_i ^ m_i)).
  - c_0 = 0.
  - carry = c_WIDTH.
  - The result must equal the unsigned (a+m) mod 2^WIDTH, with carry = 1 exactly when a+m > 2^WIDTH-1.
- Latency: 1 cycle. If in_valid=1 at edge N (rst=0), then after edge N sum/carry hold the result for the a/m sampled at edge N, and out_valid=1.
- If in_valid=0 at an edge (rst=0), sum and carry hold their previous values and out_valid=0.
- Throughput: one addition per cycle. Back-to-back valid operands produce back-to-back results in order.
- There is no handshake back-pressure; the consumer must accept results when out_valid=1.
- Wrap-around: overflow wraps mod 2^WIDTH. No saturation and no error flag.
- Operands are unsigned; there is no signed-overflow output.
- No X propagation from the holding path. After the first reset, all outputs are always defined.
- Outputs before the first reset are unspecified; the bench must apply reset first.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=0xFF, m=0x01 -> sum=0x00, carry=0, out_valid=0 after each edge.
- Exhaustive: after reset, drive all 65536 (a,m) pairs with in_valid=1 back-to-back. The result appearing on the edge after each pair must be sum=(a+m)[7:0] and carry=(a+m>255), with out_valid=1 throughout.
- Boundaries, each checked on the next edge:
  - a=0xFF, m=0x01 -> sum=0x00, carry=1.
  - a=0xFF, m=0xFF -> sum=0xFE, carry=1.
  - a=0x80, m=0x7F -> sum=0xFF, carry=0.
  - a=0, m=0 -> sum=0, carry=0.
- Hold: load a=0x12, m=0x34, which gives sum=0x46, carry=0. Then drop in_valid for 3 cycles while toggling a/m -> sum stays 0x46, carry stays 0, and out_valid=0.
- Reset mid-stream: while issuing valid operands, assert rst for 1 cycle -> on that edge outputs clear to 0 and out_valid=0. The next valid pair afterwards produces the correct result 1 cycle later.
